// File: rtl/des_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : des_pkg                                                           |
// | Brief  : Shared DES widths, key-schedule shift mask and engine state type. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package des_pkg;
  localparam int BLOCK_W  = 64;
  localparam int KEY_W    = 56;
  localparam int HALF_W   = 32;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  // Bit n-1 set: round n rotates C/D by one place instead of two.
  localparam logic [15:0] ONE_SHIFT_MASK = 16'h8103;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] v, input logic one);
    return one ? {v[CD_W-2:0], v[CD_W-1]} : {v[CD_W-3:0], v[CD_W-1:CD_W-2]};
  endfunction
endpackage
`default_nettype wire

// File: rtl/des_perm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : expansion, s_function, p_post_sf, p_key2, p_initial, p_inverse    |
// | Brief  : DES fixed permutations and S-boxes; MSB of each bus = DES bit 1.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module expansion import des_pkg::*; (
  input  logic [HALF_W-1:0]   i_r,
  output logic [SUBKEY_W-1:0] o_e
);
  localparam int TAB [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign o_e[47-i] = i_r[32-TAB[i]];
  end
endmodule

module s_function import des_pkg::*; (
  input  logic [SUBKEY_W-1:0] i_x,
  output logic [HALF_W-1:0]   o_s
);
  localparam int SBOX [0:7][0:63] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};
  for (genvar j = 0; j < 8; j++) begin : g_box
    logic [5:0] w_six;
    assign w_six = i_x[47-6*j -: 6];
    // Row = outer bits {b1,b6}, column = inner bits b2..b5.
    assign o_s[31-4*j -: 4] = 4'(SBOX[j][{w_six[5], w_six[0], w_six[4:1]}]);
  end
endmodule

module p_post_sf import des_pkg::*; (
  input  logic [HALF_W-1:0] i_s,
  output logic [HALF_W-1:0] o_p
);
  localparam int TAB [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign o_p[31-i] = i_s[32-TAB[i]];
  end
endmodule

module p_key2 import des_pkg::*; (
  input  logic [KEY_W-1:0]    i_cd,
  output logic [SUBKEY_W-1:0] o_k
);
  localparam int TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // PC-2 discards eight key bits by design.
  logic w_unused_bits;
  assign w_unused_bits = ^i_cd;
  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign o_k[47-i] = i_cd[56-TAB[i]];
  end
endmodule

module p_initial import des_pkg::*; (
  input  logic [BLOCK_W-1:0] i_x,
  output logic [BLOCK_W-1:0] o_y
);
  localparam int TAB [0:63] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign o_y[63-i] = i_x[64-TAB[i]];
  end
endmodule

module p_inverse import des_pkg::*; (
  input  logic [BLOCK_W-1:0] i_x,
  output logic [BLOCK_W-1:0] o_y
);
  localparam int TAB [0:63] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign o_y[63-i] = i_x[64-TAB[i]];
  end
endmodule
`default_nettype wire

// File: rtl/des_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : des_round                                                         |
// | Brief  : One combinational DES Feistel round including the C/D rotation.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module des_round import des_pkg::*; (
  input  logic [3:0]        i_round,
  input  logic [HALF_W-1:0] i_l,
  input  logic [HALF_W-1:0] i_r,
  input  logic [CD_W-1:0]   i_c,
  input  logic [CD_W-1:0]   i_d,
  output logic [HALF_W-1:0] o_l,
  output logic [HALF_W-1:0] o_r,
  output logic [CD_W-1:0]   o_c,
  output logic [CD_W-1:0]   o_d
);
  logic                w_one_shift;
  logic [SUBKEY_W-1:0] w_exp;
  logic [SUBKEY_W-1:0] w_subkey;
  logic [HALF_W-1:0]   w_sbox;
  logic [HALF_W-1:0]   w_f;

  // The subkey for round n is taken after that round's rotation.
  assign w_one_shift = ONE_SHIFT_MASK[i_round];
  assign o_c         = rotl_cd(i_c, w_one_shift);
  assign o_d         = rotl_cd(i_d, w_one_shift);

  expansion  u_exp  (.i_r(i_r),          .o_e(w_exp));
  p_key2     u_pc2  (.i_cd({o_c, o_d}),  .o_k(w_subkey));
  s_function u_sbox (.i_x(w_exp ^ w_subkey), .o_s(w_sbox));
  p_post_sf  u_perm (.i_s(w_sbox),       .o_p(w_f));

  assign o_l = i_r;
  assign o_r = i_l ^ w_f;
endmodule
`default_nettype wire

// File: rtl/des_encrypt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : des_encrypt_iter                                                  |
// | Brief  : Iterative DES encryptor, UNROLL rounds per clock, valid/ready.    |
// |          Define DES_ENC_CBC_EN to add the CBC chain (iv_load / iv ports).   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module des_encrypt_iter import des_pkg::*; #(
  parameter int UNROLL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  plaintext,
  input  logic [KEY_W-1:0]    key,
`ifdef DES_ENC_CBC_EN
  input  logic                iv_load,
  input  logic [BLOCK_W-1:0]  iv,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  ciphertext
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("des_encrypt_iter: UNROLL must be 1, 2 or 4");
  end

  localparam logic [3:0] STEP     = 4'(UNROLL);
  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - UNROLL);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [HALF_W-1:0]   l_q, l_d, r_q, r_d;
  logic [CD_W-1:0]     c_q, c_d, d_q, d_d;
  logic [BLOCK_W-1:0]  ct_q, ct_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  logic                accept;
  logic [BLOCK_W-1:0]  block_in;
  logic [BLOCK_W-1:0]  ip_out;
  logic [BLOCK_W-1:0]  fp_out;
  logic [UNROLL:0][HALF_W-1:0] l_w, r_w;
  logic [UNROLL:0][CD_W-1:0]   c_w, d_w;

  assign accept = in_valid && in_ready_q;

`ifdef DES_ENC_CBC_EN
  logic [BLOCK_W-1:0] chain_q, chain_d;

  // An iv_load coinciding with the accept chains this block off the new iv.
  assign block_in = plaintext ^ (iv_load ? iv : chain_q);

  always_comb begin
    chain_d = chain_q;
    if (state_q == IDLE && iv_load) chain_d = iv;
    if (state_q == DONE && out_ready) chain_d = ct_q;
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end
`else
  assign block_in = plaintext;
`endif

  p_initial u_ip (.i_x(block_in), .o_y(ip_out));

  assign l_w[0] = l_q;
  assign r_w[0] = r_q;
  assign c_w[0] = c_q;
  assign d_w[0] = d_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    des_round u_round (
      .i_round(cnt_q + 4'(k)),
      .i_l(l_w[k]), .i_r(r_w[k]), .i_c(c_w[k]), .i_d(d_w[k]),
      .o_l(l_w[k+1]), .o_r(r_w[k+1]), .o_c(c_w[k+1]), .o_d(d_w[k+1])
    );
  end

  // Halves are swapped before the final permutation.
  p_inverse u_fp (.i_x({r_w[UNROLL], l_w[UNROLL]}), .o_y(fp_out));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          l_d     = ip_out[63:32];
          r_d     = ip_out[31:0];
          c_d     = key[55:28];
          d_d     = key[27:0];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d = l_w[UNROLL];
        r_d = r_w[UNROLL];
        c_d = c_w[UNROLL];
        d_d = d_w[UNROLL];
        if (cnt_q == LAST_CNT) begin
          ct_d        = fp_out;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
endmodule
`default_nettype wire

// File: tb/tb_des_encrypt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_des_encrypt_iter                                               |
// | Brief  : Directed-vector bench for des_encrypt_iter at UNROLL 1, 2 and 4.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_des_encrypt_iter;
  localparam int          N_DUT    = 3;
  localparam logic [63:0] CT_ZERO  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] PT_STD   = 64'h0123456789ABCDEF;
  localparam logic [55:0] KEY_STD  = 56'hF0CCAAF556678F;
  localparam logic [63:0] CT_STD   = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid   [N_DUT];
  logic        in_ready   [N_DUT];
  logic [63:0] plaintext  [N_DUT];
  logic [55:0] key        [N_DUT];
  logic        out_valid  [N_DUT];
  logic        out_ready  [N_DUT];
  logic [63:0] ciphertext [N_DUT];
`ifdef DES_ENC_CBC_EN
  logic        iv_load    [N_DUT];
  logic [63:0] iv         [N_DUT];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Instance g has UNROLL = 2**g.
  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    des_encrypt_iter #(.UNROLL(1 << g)) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .plaintext(plaintext[g]),
      .key(key[g]),
`ifdef DES_ENC_CBC_EN
      .iv_load(iv_load[g]),
      .iv(iv[g]),
`endif
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .ciphertext(ciphertext[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int idx, input logic [63:0] pt, input logic [55:0] k);
    int w = 0;
    while (in_ready[idx] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("ready_before_accept", 64'(in_ready[idx]), 64'd1);
    in_valid[idx]  = 1'b1;
    plaintext[idx] = pt;
    key[idx]       = k;
    tick();
    in_valid[idx]  = 1'b0;
  endtask

  // Returns cycles from the accept edge until out_valid is seen; 40 means timeout.
  task automatic wait_out(input int idx, input bit scramble, output int lat);
    lat = 0;
    while (out_valid[idx] !== 1'b1 && lat < 40) begin
      if (scramble) begin
        plaintext[idx] = {$urandom, $urandom};
        key[idx]       = {24'($urandom), $urandom};
        in_valid[idx]  = 1'($urandom);
        out_ready[idx] = 1'($urandom);
      end
      tick();
      lat++;
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b0;
  endtask

  task automatic take_out(input int idx);
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
  endtask

  task automatic run_block(input int idx, input logic [63:0] pt, input logic [55:0] k,
                           input logic [63:0] exp, input bit scramble, input string tag);
    int lat;
    start_block(idx, pt, k);
    wait_out(idx, scramble, lat);
    check({tag, "_latency"}, 64'(lat), 64'(16 >> idx));
    check({tag, "_ct"}, ciphertext[idx], exp);
    take_out(idx);
    check({tag, "_valid_drop"}, 64'(out_valid[idx]), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready[idx]), 64'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    for (int i = 0; i < N_DUT; i++) begin
      in_valid[i]  = 1'b0;
      plaintext[i] = '0;
      key[i]       = '0;
      out_ready[i] = 1'b0;
`ifdef DES_ENC_CBC_EN
      // iv_load held high with iv=0 keeps every block effectively ECB.
      iv_load[i]   = 1'b1;
      iv[i]        = '0;
`endif
    end

    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < N_DUT; i++) begin
      check("reset_in_ready", 64'(in_ready[i]), 64'd0);
      check("reset_out_valid", 64'(out_valid[i]), 64'd0);
      check("reset_ct", ciphertext[i], 64'd0);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < N_DUT; i++) check("ready_after_reset", 64'(in_ready[i]), 64'd1);

    run_block(0, 64'd0, 56'd0, CT_ZERO, 1'b0, "zero_u1");
    run_block(0, PT_STD, KEY_STD, CT_STD, 1'b0, "std_u1");
    run_block(1, PT_STD, KEY_STD, CT_STD, 1'b0, "std_u2");
    run_block(2, PT_STD, KEY_STD, CT_STD, 1'b0, "std_u4");
    run_block(1, 64'd0, 56'd0, CT_ZERO, 1'b0, "zero_u2");

    // Back-pressure in DONE with stray in_valid pulses.
    start_block(0, 64'd0, 56'd0);
    wait_out(0, 1'b0, lat);
    check("hold_latency", 64'(lat), 64'd16);
    for (int i = 0; i < 10; i++) begin
      in_valid[0]  = 1'(i % 2);
      plaintext[0] = {$urandom, $urandom};
      key[0]       = KEY_STD;
      tick();
      check("hold_out_valid", 64'(out_valid[0]), 64'd1);
      check("hold_in_ready", 64'(in_ready[0]), 64'd0);
      check("hold_ct", ciphertext[0], CT_ZERO);
    end
    in_valid[0] = 1'b0;
    take_out(0);
    repeat (3) tick();
    check("post_hold_idle_ready", 64'(in_ready[0]), 64'd1);
    check("post_hold_no_valid", 64'(out_valid[0]), 64'd0);

    // Reset during round 7 discards the block.
    start_block(0, PT_STD, KEY_STD);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_ct_cleared", ciphertext[0], 64'd0);
    check("midrst_in_ready_low", 64'(in_ready[0]), 64'd0);
    tick();
    check("midrst_in_ready_back", 64'(in_ready[0]), 64'd1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    check("midrst_no_valid_pulse", 64'(seen), 64'd0);
    run_block(0, PT_STD, KEY_STD, CT_STD, 1'b0, "after_rst_u1");

    // Inputs thrashed every cycle while running.
    run_block(0, PT_STD, KEY_STD, CT_STD, 1'b1, "scramble_u1");
    run_block(2, 64'd0, 56'd0, CT_ZERO, 1'b1, "scramble_u4");

`ifdef DES_ENC_CBC_EN
    // Chain starts at zero, so the second block re-enciphers zero.
    iv_load[0] = 1'b1;
    iv[0]      = '0;
    tick();
    iv_load[0] = 1'b0;
    run_block(0, 64'd0, 56'd0, CT_ZERO, 1'b0, "cbc_blk1");
    run_block(0, CT_ZERO, 56'd0, CT_ZERO, 1'b0, "cbc_blk2");
    // iv loaded in the accept cycle supplies this block's chain value.
    iv_load[0] = 1'b1;
    iv[0]      = PT_STD;
    start_block(0, 64'd0, KEY_STD);
    iv_load[0] = 1'b0;
    iv[0]      = '0;
    wait_out(0, 1'b0, lat);
    check("cbc_iv_latency", 64'(lat), 64'd16);
    check("cbc_iv_ct", ciphertext[0], CT_STD);
    take_out(0);
    run_block(0, CT_STD ^ PT_STD, KEY_STD, CT_STD, 1'b0, "cbc_chain");
    iv_load[0] = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
